// File: rtl/mac_frame_ctrl.sv
// mac_frame_ctrl
// Frame sequencer for the audio multiply-accumulate path. It gates the
// sample handshake between the line-in stream and the MAC. It clears the MAC
// accumulator at the start of each frame and counts accepted samples and
// MAC result beats. It holds the final running sum of each frame for the
// display path.
//
// Ports
//   clk_i           clock
//   reset_i         synchronous active-high reset
//   valid_i         upstream sample valid
//   ready_o         upstream sample ready (combinational)
//   mac_valid_o     sample valid into the MAC (combinational)
//   mac_ready_i     MAC ready for a sample
//   mac_clear_o     accumulator clear, drives the MAC reset
//   mac_valid_i     MAC result valid (always accepted)
//   mac_data_i      MAC running sum, signed
//   result_valid_o  captured frame result available
//   result_ready_i  consumer takes the captured result
//   result_data_o   captured frame sum, signed
//   overrun_o       sticky: a frame result overwrote an unconsumed one
//   in_count_o      samples accepted in the current frame
//
// state | meaning
// CLEAR | one-cycle MAC clear, counters zeroed, upstream blocked
// RUN   | samples pass through to the MAC until the frame is full
// DRAIN | upstream blocked, waiting for the last MAC result beat

module mac_frame_ctrl #(
  parameter int frame_len_p = 44100,
  parameter int acc_width_p = 32,
  parameter int cnt_width_p = $clog2(frame_len_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          mac_valid_o,
  input  logic                          mac_ready_i,
  output logic                          mac_clear_o,
  input  logic                          mac_valid_i,
  input  logic signed [acc_width_p-1:0] mac_data_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic signed [acc_width_p-1:0] result_data_o,
  output logic                          overrun_o,
  output logic [cnt_width_p-1:0]        in_count_o
);

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

  localparam logic [cnt_width_p-1:0] frame_len_c = cnt_width_p'(frame_len_p);
  localparam logic [cnt_width_p-1:0] last_c      = cnt_width_p'(frame_len_p - 1);
  localparam logic [cnt_width_p-1:0] one_c       = cnt_width_p'(1);

  state_t                   state, state_n;
  logic [cnt_width_p-1:0]   in_cnt, out_cnt;
  logic                     accept;
  logic                     beat;
  logic                     capture;
  logic                     clear_q;

  // Result beats are ignored in CLEAR and the count saturates at a full frame.
  assign beat    = mac_valid_i && (state != CLEAR) && (out_cnt != frame_len_c);
  assign capture = beat && (out_cnt == last_c);

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= CLEAR;
    else         state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ready_o     = 1'b0;
    mac_valid_o = 1'b0;
    accept      = 1'b0;
    case (state)
      CLEAR: state_n = RUN;
      RUN: begin
        ready_o     = mac_ready_i;
        mac_valid_o = valid_i;
        accept      = valid_i && mac_ready_i;
        // A zero-latency MAC can deliver the capture beat with the final accept.
        if (capture)
          state_n = CLEAR;
        else if (accept && (in_cnt == last_c))
          state_n = DRAIN;
      end
      DRAIN: begin
        if (capture) state_n = CLEAR;
      end
      default: state_n = CLEAR;
    endcase
  end

  // mac_clear_o is registered from the next-state decode so it is high
  // exactly while the state register holds CLEAR.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clear_q        <= 1'b1;
      in_cnt         <= '0;
      out_cnt        <= '0;
      result_valid_o <= 1'b0;
      result_data_o  <= '0;
      overrun_o      <= 1'b0;
    end else begin
      clear_q <= (state_n == CLEAR);
      if (state == CLEAR) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (accept && (in_cnt != frame_len_c)) in_cnt <= in_cnt + one_c;
        if (beat)                              out_cnt <= out_cnt + one_c;
      end
      if (capture) begin
        result_data_o  <= mac_data_i;
        result_valid_o <= 1'b1;
        if (result_valid_o && !result_ready_i) overrun_o <= 1'b1;
      end else if (result_valid_o && result_ready_i) begin
        result_valid_o <= 1'b0;
      end
    end
  end

  assign mac_clear_o = clear_q;
  assign in_count_o  = in_cnt;

endmodule

// File: tb/tb_mac_frame_ctrl.sv
module tb_mac_frame_ctrl;
  localparam int FL = 4;
  localparam int AW = 32;
  localparam int CW = $clog2(FL + 1);

  logic                 clk_i = 1'b0;
  logic                 reset_i = 1'b1;
  logic                 valid_i = 1'b0;
  logic                 ready_o;
  logic                 mac_valid_o;
  logic                 mac_ready_i = 1'b1;
  logic                 mac_clear_o;
  logic                 mac_valid_i;
  logic signed [AW-1:0] mac_data_i;
  logic                 result_valid_o;
  logic                 result_ready_i = 1'b0;
  logic signed [AW-1:0] result_data_o;
  logic                 overrun_o;
  logic [CW-1:0]        in_count_o;

  int checks = 0;
  int errors = 0;

  logic signed [AW-1:0] din = '0;
  logic signed [AW-1:0] acc_m;

  always #5 clk_i = ~clk_i;

  mac_frame_ctrl #(.frame_len_p(FL), .acc_width_p(AW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i), .mac_clear_o(mac_clear_o),
    .mac_valid_i(mac_valid_i), .mac_data_i(mac_data_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_data_o(result_data_o), .overrun_o(overrun_o), .in_count_o(in_count_o)
  );

  // One-cycle-latency MAC: product equals the sample, output is running sum.
  always @(posedge clk_i) begin
    if (mac_clear_o) begin
      acc_m       <= '0;
      mac_data_i  <= '0;
      mac_valid_i <= 1'b0;
    end else if (mac_valid_o && mac_ready_i) begin
      acc_m       <= acc_m + din;
      mac_data_i  <= acc_m + din;
      mac_valid_i <= 1'b1;
    end else begin
      mac_valid_i <= 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1; valid_i = 1'b0; mac_ready_i = 1'b1; result_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Streams four samples with mac_ready_i high, then waits for the CLEAR cycle.
  // Returns at the negedge inside the CLEAR cycle that follows the capture.
  task automatic stream_frame(input int s0, input int s1, input int s2, input int s3,
                              input logic consume_on_capture);
    int s[4];
    logic take;
    int n;
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      din = s[i];
      n = 0;
      do begin
        #1 take = ready_o;
        @(negedge clk_i);
        n++;
      end while (!take && n < 20);
      if (!take) begin
        checks++; errors++;
        $display("FAIL stream_accept sample %0d never accepted", i);
      end
    end
    valid_i = 1'b0;
    result_ready_i = consume_on_capture;
    n = 0;
    while (!mac_clear_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    result_ready_i = 1'b0;
    checks++;
    if (mac_clear_o !== 1'b1) begin
      errors++;
      $display("FAIL frame_clear got %b want 1 (timeout)", mac_clear_o);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; valid_i = 1'b0; mac_ready_i = 1'b1; result_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({mac_clear_o, ready_o, mac_valid_o} !== 3'b100) begin
      errors++; $display("FAIL reset_ctrl got %b want 100", {mac_clear_o, ready_o, mac_valid_o});
    end
    checks++;
    if ({result_valid_o, overrun_o} !== 2'b00 || result_data_o !== 0 || in_count_o !== 0) begin
      errors++;
      $display("FAIL reset_regs got rv=%b ov=%b data=%0d cnt=%0d want 0", result_valid_o,
               overrun_o, result_data_o, in_count_o);
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (mac_clear_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_clear got clr=%b rdy=%b want 1 0", mac_clear_o, ready_o);
    end
    @(negedge clk_i);
    checks++;
    if (mac_clear_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL run_entry got clr=%b rdy=%b want 0 1", mac_clear_o, ready_o);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; din = i + 1;
      #1;
      checks++;
      if (ready_o !== 1'b1) begin
        errors++; $display("FAIL single_ready[%0d] got %b want 1", i, ready_o);
      end
      @(negedge clk_i);
      checks++;
      if (in_count_o !== CW'(i + 1)) begin
        errors++; $display("FAIL single_count[%0d] got %0d want %0d", i, in_count_o, i + 1);
      end
    end
    valid_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_drain got rdy=%b rv=%b want 0 0", ready_o, result_valid_o);
    end
    @(negedge clk_i);
    checks++;
    if (result_valid_o !== 1'b1 || result_data_o !== 10 || mac_clear_o !== 1'b1) begin
      errors++;
      $display("FAIL single_capture got rv=%b data=%0d clr=%b want 1 10 1", result_valid_o,
               result_data_o, mac_clear_o);
    end
    @(negedge clk_i);
    checks++;
    if (mac_clear_o !== 1'b0 || in_count_o !== 0) begin
      errors++; $display("FAIL single_rerun got clr=%b cnt=%0d want 0 0", mac_clear_o, in_count_o);
    end
  endtask

  task automatic test_backpressure();
    logic pat[7];
    int   exp_cnt[7];
    int   smp[4];
    int   idx;
    pat     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_cnt = '{1, 1, 2, 2, 3, 3, 4};
    smp     = '{2, 3, 4, 5};
    do_reset();
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      valid_i = 1'b1; mac_ready_i = pat[k]; din = smp[idx];
      #1;
      checks++;
      if (ready_o !== pat[k]) begin
        errors++; $display("FAIL bp_ready[%0d] got %b want %b", k, ready_o, pat[k]);
      end
      @(negedge clk_i);
      checks++;
      if (in_count_o !== CW'(exp_cnt[k])) begin
        errors++; $display("FAIL bp_count[%0d] got %0d want %0d", k, in_count_o, exp_cnt[k]);
      end
      if (pat[k] && idx < 3) idx++;
    end
    valid_i = 1'b0; mac_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (result_valid_o !== 1'b1 || result_data_o !== 14 || mac_clear_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_capture got rv=%b data=%0d clr=%b want 1 14 1", result_valid_o,
               result_data_o, mac_clear_o);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    stream_frame(1, 1, 1, 1, 1'b0);
    checks++;
    if (result_valid_o !== 1'b1 || result_data_o !== 4 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first got rv=%b data=%0d ov=%b want 1 4 0", result_valid_o,
               result_data_o, overrun_o);
    end
    stream_frame(2, 2, 2, 2, 1'b0);
    checks++;
    if (result_data_o !== 8 || overrun_o !== 1'b1) begin
      errors++; $display("FAIL ovr_second got data=%0d ov=%b want 8 1", result_data_o, overrun_o);
    end
    stream_frame(3, 3, 3, 3, 1'b0);
    checks++;
    if (result_data_o !== 12 || overrun_o !== 1'b1 || result_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL ovr_third got data=%0d ov=%b rv=%b want 12 1 1", result_data_o,
               overrun_o, result_valid_o);
    end
  endtask

  task automatic test_capture_consume();
    do_reset();
    stream_frame(1, 2, 3, 4, 1'b0);
    checks++;
    if (result_valid_o !== 1'b1 || result_data_o !== 10) begin
      errors++; $display("FAIL cc_first got rv=%b data=%0d want 1 10", result_valid_o, result_data_o);
    end
    stream_frame(5, 6, 7, 8, 1'b1);
    checks++;
    if (result_valid_o !== 1'b1 || result_data_o !== 26 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL cc_second got rv=%b data=%0d ov=%b want 1 26 0", result_valid_o,
               result_data_o, overrun_o);
    end
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    checks++;
    if (result_valid_o !== 1'b0) begin
      errors++; $display("FAIL cc_consume got rv=%b want 0", result_valid_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    stream_frame(1, 1, 1, 1, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b1; din = 9;
    repeat (2) @(negedge clk_i);
    checks++;
    if (in_count_o !== 2) begin
      errors++; $display("FAIL mid_partial got %0d want 2", in_count_o);
    end
    valid_i = 1'b0; reset_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (in_count_o !== 0 || result_valid_o !== 1'b0 || mac_clear_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d rv=%b clr=%b want 0 0 1", in_count_o,
               result_valid_o, mac_clear_o);
    end
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    stream_frame(5, 5, 5, 5, 1'b0);
    checks++;
    if (result_valid_o !== 1'b1 || result_data_o !== 20) begin
      errors++; $display("FAIL mid_result got rv=%b data=%0d want 1 20", result_valid_o, result_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_overrun();
    test_capture_consume();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mac_frame_ctrl.md
# mac_frame_ctrl

Frame sequencer for the audio multiply-accumulate path. It gates the sample handshake between the deserialized line-in stream and the MAC. It clears the MAC accumulator at the start of every frame and counts accepted samples. When the MAC emits the result for the last sample of a frame, it captures that result into a held output register for the display path.

## Interface
- `frame_len_p`, 44100: samples per frame; legal range 1 .. 2^20.
- `acc_width_p`, 32: width of the MAC accumulator result.
- `cnt_width_p`, `$clog2(frame_len_p+1)`: width of the internal sample counters; not overridden by users.

- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  upstream sample valid (sipo stream).
- `ready_o`  out  1  upstream sample ready.
- `mac_valid_o`  out  1  sample valid into the MAC.
- `mac_ready_i`  in  1  MAC ready for a sample.
- `mac_clear_o`  out  1  accumulator clear, connected to the MAC reset.
- `mac_valid_i`  in  1  MAC result valid; the controller always accepts it, so the MAC's ready input is tied to 1.
- `mac_data_i`  in  acc_width_p  MAC running-sum result, signed.
- `result_valid_o`  out  1  captured frame result is available.
- `result_ready_i`  in  1  consumer accepts the captured result.
- `result_data_o`  out  acc_width_p  captured frame sum, signed.
- `overrun_o`  out  1  sticky flag: a frame result overwrote an unconsumed result.
- `in_count_o`  out  cnt_width_p  number of samples accepted in the current frame.

## Operation
- States: `CLEAR`, `RUN`, `DRAIN`. Reset forces `CLEAR`.
- **CLEAR** (exactly one cycle):
  - `mac_clear_o` = 1; `ready_o` = 0; `mac_valid_o` = 0.
  - `in_cnt` and `out_cnt` are zeroed.
  - Always transitions to `RUN`.
- **RUN**:
  - `mac_valid_o` = `valid_i`; `ready_o` = `mac_ready_i`; `mac_clear_o` = 0.
  - A sample is accepted ("accept") when `valid_i & mac_ready_i`. Each accept increments `in_cnt`.
  - An accept while `in_cnt == frame_len_p-1` is the final sample. It increments `in_cnt` to `frame_len_p`, and the FSM moves to `DRAIN`.
- **DRAIN**:
  - `ready_o` = 0; `mac_valid_o` = 0. Upstream stalls; sipo buffers the backpressure.
  - `mac_clear_o` = 0.
- **Output-beat counting** (in RUN and DRAIN):
  - Every cycle with `mac_valid_i` = 1 increments `out_cnt`.
  - The beat on which `out_cnt` becomes `frame_len_p` is the capture beat.
  - On the capture beat: `result_data_o <= mac_data_i`, `result_valid_o <= 1`, and the FSM moves to `CLEAR`.
  - The capture beat may occur in RUN only when the MAC has zero latency. In that case it coincides with the final accept, and the FSM goes directly to `CLEAR`.
- **Result register**:
  - `result_valid_o` clears on `result_valid_o & result_ready_i`.
  - If a capture happens in the same cycle as a consume, the new result is loaded and `result_valid_o` stays 1.
  - If a capture happens while `result_valid_o` = 1 and `result_ready_i` = 0, the new data overwrites the old, and `overrun_o` sets to 1.
  - `overrun_o` is cleared only by `reset_i`.
- `mac_valid_i` is ignored in `CLEAR` and does not count.
- `in_count_o` = `in_cnt`.
- The counters never wrap; they saturate at `frame_len_p` until `CLEAR`.

## Timing
- Reset values:
  - State = `CLEAR`, so `mac_clear_o` = 1 while `reset_i` is high and in the first cycle after release.
  - `ready_o` = 0, `mac_valid_o` = 0, `result_valid_o` = 0, `result_data_o` = 0, `overrun_o` = 0, `in_count_o` = 0.
- Reset mid-frame discards the partial frame and the counts. A held result is also discarded (`result_valid_o` = 0).
- `ready_o` and `mac_valid_o` are combinational from state and inputs, with no added latency. All other outputs are registered.
- Frame turnaround: capture-beat cycle, then one `CLEAR` cycle, then `RUN`. With a single-cycle MAC, the upstream is blocked for 2 cycles per frame.
- `result_valid_o` rises the cycle after the capture beat.

## Test plan
All scenarios use `frame_len_p` = 4 and a 1-cycle-latency MAC model.

1. **Reset release.** Hold reset for 3 cycles, then release. Required:
   - `mac_clear_o` = 1 through the first post-reset cycle, then 0.
   - `ready_o` = 0 in that cycle.
   - All registered outputs are 0.
2. **Single frame.** Stream samples 1, 2, 3, 4 (products 1, 2, 3, 4) back-to-back. Required:
   - `in_count_o` steps 1→4.
   - `ready_o` drops after the 4th accept.
   - `result_data_o` = 10 and `result_valid_o` = 1 one cycle after the 4th MAC beat.
   - A `CLEAR` pulse follows.
3. **Backpressure.** Toggle `mac_ready_i` 1,0,1,0 while `valid_i` = 1. Required:
   - `ready_o` mirrors `mac_ready_i`.
   - Only accept cycles increment `in_count_o`.
   - The capture still occurs after exactly 4 accepts.
4. **Overrun.** Run two frames with `result_ready_i` = 0. Required:
   - The second result overwrites the first.
   - `overrun_o` = 1 and stays 1 across a third frame.
5. **Simultaneous capture and consume.** Assert `result_ready_i` on the capture-beat cycle of frame 2. Required: `result_valid_o` stays 1 with frame-2 data, and `overrun_o` = 0.
6. **Reset mid-frame.** Assert reset after 2 accepts, then run a full frame of 5s. Required: the captured result equals 20, with no contribution from the pre-reset samples.
